// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 20;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = DIV_IDLE,
        ST_RUN  = DIV_RUN,
        ST_DONE = DIV_DONE
    } div_state_e;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: compare the shifted partial remainder with the
// divisor and subtract when it fits.
module div_sub_stage #(
    parameter int unsigned WIDTH = 20
) (
    input  logic [WIDTH:0]   t,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);

    logic [WIDTH:0] dvsr_ext;

    assign dvsr_ext = {1'b0, divisor};
    assign q_bit    = (t >= dvsr_ext);
    assign r_next   = q_bit ? (t - dvsr_ext) : t;

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// Optional feature: DIV_ZERO_DETECT_EN enables the divide-by-zero early-out.
module iter_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
    logic             dbz_q, dbz_d;
`endif

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   r_next;
    logic             q_bit;

    assign t = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .t       (t),
        .divisor (dvsr_q),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    // Next-state, iteration and output-register logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
        dbz_d   = dbz_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvsr_d = divisor;
                    q_d    = dividend;
                    r_d    = '0;
                    cnt_d  = '0;
                    state_d = ST_RUN;
`ifdef DIV_ZERO_DETECT_EN
                    dbz_d  = 1'b0;
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
`endif
                end
            end
            ST_RUN: begin
                q_d   = {q_q[WIDTH-2:0], q_bit};
                r_d   = r_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    quot_d  = {q_q[WIDTH-2:0], q_bit};
                    rem_d   = r_next[WIDTH-1:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy covers the whole RUN stretch including the edge that leaves it;
        // done trails the internal DONE state by one register stage.
        busy_d = (state_d == ST_RUN) || (state_q == ST_RUN);
        done_d = (state_q == ST_DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed cases plus random operands
// checked against plain integer division.
module tb_iter_divider;

    localparam int unsigned W = 20;
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int passes = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit zero_early(input logic [W-1:0] b);
`ifdef DIV_ZERO_DETECT_EN
        return (b == '0);
`else
        return 1'b0;
`endif
    endfunction

    // Issue one operation from IDLE and check latency, busy length and results.
    // pulse_at >= 0 re-pulses start with 7/7 that many cycles into the run.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int pulse_at);
        logic [W-1:0] eq, er;
        int n, busy_n, elat, ebusy;
        bit seen;
        eq    = (b == '0) ? ALL_ONES : W'(a / b);
        er    = (b == '0) ? a : W'(a % b);
        elat  = zero_early(b) ? 1 : W + 1;
        ebusy = zero_early(b) ? 0 : W + 1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        busy_n = int'(busy);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (n == pulse_at) begin
                start = 1'b1; dividend = 7; divisor = 7;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (done) seen = 1'b1;
            else busy_n += int'(busy);
        end
        check({tag, ".latency"}, n, elat);
        check({tag, ".busy_cycles"}, busy_n, ebusy);
        check({tag, ".quotient"}, quotient, eq);
        check({tag, ".remainder"}, remainder, er);
        check({tag, ".div_by_zero"}, div_by_zero, zero_early(b));
        @(posedge clk); #1;
        check({tag, ".done_pulse_len"}, done, 0);
        check({tag, ".quotient_held"}, quotient, eq);
    endtask

    initial begin
        int done_cnt, last_done, n;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.quotient", quotient, 0);
        check("reset.remainder", remainder, 0);
        check("reset.div_by_zero", div_by_zero, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("d100_7", 100, 7, -1);
        run_op("max_by_1", 20'hFFFFF, 1, -1);
        run_op("d5_9", 5, 9, -1);
        run_op("div0", 1234, 0, -1);
        run_op("ign_start", 1000, 10, 5);
        repeat (5) @(posedge clk);
        #1;
        check("hold.quotient", quotient, 100);
        check("hold.remainder", remainder, 0);
        check("hold.done", done, 0);

        // Abort mid-run with reset; no done may follow
        dividend = 50000; divisor = 3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.quotient", quotient, 0);
        check("abort.remainder", remainder, 0);
        check("abort.div_by_zero", div_by_zero, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_cnt = 0;
        repeat (25) begin
            @(posedge clk); #1;
            done_cnt += int'(done);
        end
        check("abort.no_done", done_cnt, 0);
        run_op("after_abort", 9, 4, -1);

        // Continuous start: one done per op, every W+2 cycles
        dividend = 17; divisor = 5; start = 1'b1;
        done_cnt = 0; last_done = -1;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            if (c == 60) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (last_done >= 0) check("held.interval", c - last_done, W + 2);
                last_done = c;
                check("held.quotient", quotient, 3);
                check("held.remainder", remainder, 2);
            end
        end
        check("held.done_count", done_cnt, 3);

        // Random operands against integer division
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = (i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
            run_op($sformatf("rand%0d", i), a, b, -1);
        end

        n = 0;
        while ((busy || done) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("final.idle", int'(busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
# iter_divider

Multi-cycle unsigned restoring divider. Computes quotient and remainder of two WIDTH-bit operands by one conditional subtraction per clock, the inverse operation to the datapath's 20-bit adder. It sits beside the ALU as the slow path for divide instructions. A start/busy/done handshake lets the control unit stall until the result is valid.

## Interface
- WIDTH, 20, operand, quotient and remainder width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator; captured on the accepted start
- divisor  input  WIDTH  denominator; captured on the accepted start
- busy  output  1  high while the state is RUN
- done  output  1  one-cycle pulse; quotient and remainder are valid
- quotient  output  WIDTH  result; held until the next accepted start
- remainder  output  WIDTH  result; held until the next accepted start
- div_by_zero  output  1  divisor was 0; valid with done, held like the results

## Operation
- States:
  - IDLE: waits for start.
  - RUN: iterates. A counter runs 0..WIDTH-1.
  - DONE: lasts one cycle; done=1. Then returns to IDLE.
- Transitions:
  - IDLE & start goes to RUN. In the same edge, capture the operands and clear the partial remainder R (WIDTH+1 bits).
  - RUN goes to DONE after WIDTH iterations.
  - DONE goes to IDLE unconditionally.
- Iteration:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Shift Q left.
  - If T >= {1'b0, divisor}: R = T - divisor and Q[0] = 1. Otherwise R = T and Q[0] = 0.
  - Compare and subtract are unsigned, WIDTH+1 bits, with no overflow possible.
- quotient and remainder output registers load from Q and R[WIDTH-1:0] on entry to DONE.
- start in RUN or DONE is ignored, and operand changes have no effect. Holding start high continuously starts the next operation on the first IDLE cycle.
- Divisor 0 without early-out: the algorithm naturally gives quotient = all ones and remainder = dividend.
- Reset values: state IDLE, busy 0, done 0, quotient 0, remainder 0, div_by_zero 0, counter 0.
- An rst assertion at any time, including mid-RUN, aborts immediately to the reset values. No done pulse is produced for the aborted operation.

## Timing
- start accepted at edge k: busy=1 from edge k through edge k+WIDTH. done=1 for one cycle after edge k+WIDTH+1.
- Start-to-done latency is WIDTH+1 cycles (21 at default). Initiation interval is WIDTH+2 cycles.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- DIV_ZERO_DETECT_EN defined:
  - IDLE & start & divisor==0 goes directly to DONE, with done one cycle after the accepted start.
  - div_by_zero=1, quotient=all ones, remainder=dividend.
  - div_by_zero clears on the next accepted start.
- DIV_ZERO_DETECT_EN undefined:
  - Divide-by-zero runs the full WIDTH iterations and yields the same quotient and remainder values.
  - div_by_zero is tied to 0.

## Structure
- Package div_pkg holds:
  - state encoding localparams DIV_IDLE=2'd0, DIV_RUN=2'd1, DIV_DONE=2'd2;
  - default DIV_WIDTH=20;
  - counter width as a clog2 of WIDTH constant.
- One sub-module, div_sub_stage (combinational): takes T and divisor; returns the next R and the quotient bit. The sub-module keeps the compare/subtract isolated for reuse and for timing analysis.

## Test plan
- dividend=100, divisor=7, start for 1 cycle -> done exactly 21 cycles later, quotient=14, remainder=2, busy high for 21 cycles.
- dividend=0xFFFFF, divisor=1 -> quotient=0xFFFFF, remainder=0. Also dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=1234, divisor=0:
  - with DIV_ZERO_DETECT_EN -> done 1 cycle after start, div_by_zero=1, quotient=0xFFFFF, remainder=1234;
  - without the macro -> done after 21 cycles, same quotient and remainder, div_by_zero=0.
- Start 1000/10. Pulse start with 7/7 during RUN -> ignored; result quotient=100, remainder=0. Outputs hold their values after done until the next start.
- Assert rst at iteration 10 of 50000/3 -> all outputs 0 immediately, no done pulse. Next start 9/4 -> quotient=2, remainder=1.
- Start held high continuously with 17/5 -> results quotient=3, remainder=2, repeating every 22 cycles, exactly one done pulse per operation.
